// File: rtl/serial_coeff_mac.sv
// Bit-serial signed multiplier for one FIR tap: sequences the upstream right-shift
// register and shift-adds the parallel coefficient under each serial sample bit.
`timescale 1ns/1ps

module serial_coeff_mac #(
    parameter  int N = 20,
    parameter  int C = 16,
    localparam int P = N + C
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [C-1:0] coeff,
    input  logic         hold,
    input  logic         sample_bit,
    output logic         sr_load,
    output logic         sr_enable,
    output logic         busy,
    output logic         done,
    output logic [P-1:0] product,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Handshake: start is a level request sampled only while busy is low (IDLE);
    // anything seen while busy is dropped, not queued. done is a one-cycle pulse
    // and product stays stable from that pulse until the next one.

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] counter;
    logic [C-1:0]  coeff_q;
    logic [P-1:0]  acc;
    logic [P-1:0]  acc_next;
    logic [P-1:0]  coeff_ext;
    logic [P-1:0]  addend;
    logic [P-1:0]  product_q;
    logic          done_q;
    logic          last_bit;
    logic          shift_step;

    assign last_bit   = (counter == CW'(N - 1));
    assign shift_step = (state == S_SHIFT) && !hold;

    // The final serial bit is the sample's sign bit and carries negative weight.
    always_comb begin
        coeff_ext = {{N{coeff_q[C-1]}}, coeff_q};
        addend    = sample_bit ? (coeff_ext << counter) : '0;
        acc_next  = last_bit ? (acc - addend) : (acc + addend);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_SHIFT;
            S_SHIFT: if (shift_step && last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter <= '0;
            acc     <= '0;
            coeff_q <= '0;
        end else if (state == S_IDLE && start) begin
            counter <= '0;
            acc     <= '0;
            coeff_q <= coeff;
        end else if (shift_step) begin
            counter <= counter + 1'b1;
            acc     <= acc_next;
        end
    end

    // product takes the fully updated sum on the same edge as the sign-bit step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= shift_step && last_bit;
            if (shift_step && last_bit) begin
                product_q <= acc_next;
            end
        end
    end

    assign sr_load   = (state == S_LOAD);
    assign sr_enable = shift_step;
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign product   = product_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_coeff_mac.sv
// Bench for serial_coeff_mac with a behavioural upstream right-shift register and
// a product scoreboard fed by a multiply reference model.
`timescale 1ns/1ps

module tb_serial_coeff_mac;

    localparam int N = 20;
    localparam int C = 16;
    localparam int P = N + C;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [C-1:0] coeff;
    logic         hold;
    logic         sample_bit;
    logic         sr_load;
    logic         sr_enable;
    logic         busy;
    logic         done;
    logic [P-1:0] product;
    logic [1:0]   dbg_state;

    logic [N-1:0] sample_val;
    logic [N-1:0] up_reg;

    logic [P-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    serial_coeff_mac #(.N(N), .C(C)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .coeff     (coeff),
        .hold      (hold),
        .sample_bit(sample_bit),
        .sr_load   (sr_load),
        .sr_enable (sr_enable),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / upstream register ----------------
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (sr_load) up_reg <= sample_val;
        else if (sr_enable) up_reg <= {1'b0, up_reg[N-1:1]};
    end
    assign sample_bit = up_reg[0];

    function automatic logic [P-1:0] model(input logic [N-1:0] s, input logic [C-1:0] c);
        logic signed [P-1:0] a;
        logic signed [P-1:0] b;
        a = {{C{s[N-1]}}, s};
        b = {{N{c[C-1]}}, c};
        return a * b;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: product=%h with no pending operation", product);
            end else begin
                logic [P-1:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    errors++;
                    $display("FAIL sb_product: got %h expected %h", product, e);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [N-1:0] s, input logic [C-1:0] c);
        bit seen;
        @(negedge clk);
        sample_val = s;
        coeff = c;
        start = 1'b1;
        exp_q.push_back(model(s, c));
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL op_timeout: no done within 60 cycles for sample=%h coeff=%h", s, c);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        coeff = '0;
        sample_val = '0;
        #1;
        checks++;
        if ({busy, done, sr_load, sr_enable} !== 4'b0000 || product !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b ld=%b en=%b product=%h st=%0d required all zero",
                     busy, done, sr_load, sr_enable, product, dbg_state);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] smp[2];
        logic [C-1:0] cf[2];
        logic [P-1:0] ex[2];
        smp[0] = 20'hAAAAA; cf[0] = 16'h0001; ex[0] = 36'hFFFFAAAAA;
        smp[1] = 20'h55555; cf[1] = 16'h0003; ex[1] = 36'h0000FFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sample_val = smp[i];
            coeff = cf[i];
            start = 1'b1;
            exp_q.push_back(model(smp[i], cf[i]));
            for (int c = 1; c <= 23; c++) begin
                @(negedge clk);
                start = 1'b0;
                checks += 4;
                if (sr_load !== (c == 1)) begin
                    errors++;
                    $display("FAIL basic%0d_sr_load c=%0d: got %b expected %b", i, c, sr_load, (c == 1));
                end
                if (sr_enable !== (c >= 2 && c <= 21)) begin
                    errors++;
                    $display("FAIL basic%0d_sr_enable c=%0d: got %b expected %b", i, c, sr_enable, (c >= 2 && c <= 21));
                end
                if (done !== (c == 22)) begin
                    errors++;
                    $display("FAIL basic%0d_done c=%0d: got %b expected %b", i, c, done, (c == 22));
                end
                if (busy !== (c <= 22)) begin
                    errors++;
                    $display("FAIL basic%0d_busy c=%0d: got %b expected %b", i, c, busy, (c <= 22));
                end
            end
            checks++;
            if (product !== ex[i]) begin
                errors++;
                $display("FAIL basic%0d_product_hold: got %h expected %h", i, product, ex[i]);
            end
        end
    endtask

    task automatic test_extremes();
        do_op(20'h80000, 16'h8000);
        checks++;
        if (product !== 36'h400000000) begin
            errors++;
            $display("FAIL extreme_neg_neg: got %h expected 400000000", product);
        end
        do_op(20'hFFFFF, 16'h7FFF);
        checks++;
        if (product !== 36'hFFFFF8001) begin
            errors++;
            $display("FAIL extreme_m1_max: got %h expected fffff8001", product);
        end
    endtask

    task automatic test_hold();
        int shifts;
        int holds;
        int guard;
        @(negedge clk);
        sample_val = 20'hAAAAA;
        coeff = 16'h0005;
        start = 1'b1;
        exp_q.push_back(model(20'hAAAAA, 16'h0005));
        @(negedge clk);
        start = 1'b0;
        #5 hold = 1'b1;
        #1;
        checks++;
        if (sr_load !== 1'b1 || sr_enable !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_load: ld=%b en=%b expected ld=1 en=0", sr_load, sr_enable);
        end
        shifts = 0;
        holds = 0;
        guard = 0;
        while (shifts < N && guard < 200) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL hold_early_done: shifts=%0d holds=%0d", shifts, holds);
            end
            #5 hold = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (sr_enable !== !hold) begin
                errors++;
                $display("FAIL hold_sr_enable: got %b expected %b (hold=%b)", sr_enable, !hold, hold);
            end
            if (hold) holds++;
            else shifts++;
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL hold_budget: only %0d shifts in 200 cycles", shifts);
        end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL hold_done_cycle: done=%b at cycle %0d expected 1", done, 22 + holds);
        end
        if (product !== 36'hFFFE55552) begin
            errors++;
            $display("FAIL hold_product: got %h expected fffe55552", product);
        end
        #5 hold = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_done: busy=%b done=%b expected 0 0", busy, done);
        end
        hold = 1'b0;
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        sample_val = 20'h12345;
        coeff = 16'h0003;
        start = 1'b1;
        exp_q.push_back(model(20'h12345, 16'h0003));
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checks += 2;
            if (done !== (c == 22)) begin
                errors++;
                $display("FAIL ignore_done c=%0d: got %b expected %b", c, done, (c == 22));
            end
            if (busy !== (c <= 22)) begin
                errors++;
                $display("FAIL ignore_busy c=%0d: got %b expected %b", c, busy, (c <= 22));
            end
            if (c == 1) start = 1'b0;
            if (c == 5) begin
                start = 1'b1;
                coeff = 16'h7FFF;
            end
            if (c == 9) start = 1'b0;
        end
        checks++;
        if (product !== 36'h0000369CF) begin
            errors++;
            $display("FAIL ignore_product: got %h expected 0000369cf", product);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sample_val = 20'h00001;
        coeff = 16'h8000;
        start = 1'b1;
        exp_q.push_back(model(20'h00001, 16'h8000));
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            checks += 2;
            if (done !== (c == 22 || c == 45 || c == 68)) begin
                errors++;
                $display("FAIL b2b_done c=%0d: got %b", c, done);
            end
            if (busy !== !(c == 23 || c == 46 || c >= 69)) begin
                errors++;
                $display("FAIL b2b_busy c=%0d: got %b", c, busy);
            end
            if (c == 23) begin
                sample_val = 20'h7FFFF;
                coeff = 16'h7FFF;
                exp_q.push_back(model(20'h7FFFF, 16'h7FFF));
            end
            if (c == 46) begin
                sample_val = 20'hFFFFF;
                coeff = 16'h0001;
                exp_q.push_back(model(20'hFFFFF, 16'h0001));
            end
            if (c == 47) start = 1'b0;
        end
        checks++;
        if (product !== 36'hFFFFFFFFF) begin
            errors++;
            $display("FAIL b2b_last_product: got %h expected fffffffff", product);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        sample_val = 20'h3C3C3;
        coeff = 16'h1234;
        start = 1'b1;
        exp_q.push_back(model(20'h3C3C3, 16'h1234));
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 resetn = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({busy, done, sr_load, sr_enable} !== 4'b0000 || product !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b done=%b ld=%b en=%b product=%h required all zero",
                     busy, done, sr_load, sr_enable, product);
        end
        @(negedge clk);
        resetn = 1'b1;
        saw_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midreset_no_done: done seen after aborted operation");
        end
        do_op(20'h3C3C3, 16'h1234);
        checks++;
        if (product !== model(20'h3C3C3, 16'h1234)) begin
            errors++;
            $display("FAIL midreset_recover: got %h expected %h", product, model(20'h3C3C3, 16'h1234));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_hold();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_coeff_mac.md
Name: serial_coeff_mac

Overview:
- Bit-serial signed multiplier/accumulator directly downstream of the right-shift register stage (rshiftregne) in the FIR datapath.
- Drives that register's load/enable and consumes its serial LSB-first output Q, one bit per enabled cycle.
- Multiplies the n-bit two's-complement sample by a parallel coefficient using shift-add, and presents a full-precision product plus a one-cycle done pulse.
- Also acts as the sequencer for the serial tap.

Parameters:
- N, 20, sample width; equals the upstream shift register's n.
- C, 16, coefficient width, two's complement.
- P, N+C, product/accumulator width; fixed at N+C, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request a multiply; accepted only in IDLE.
- coeff  in  C  coefficient; captured on the edge that accepts start.
- hold  in  1  stall during SHIFT; freezes bit counter and accumulator, deasserts sr_enable.
- sample_bit  in  1  serial sample bit from upstream Q, LSB first.
- sr_load  out  1  upstream parallel-load strobe.
- sr_enable  out  1  upstream shift enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  single-cycle pulse; product valid.
- product  out  P  signed sample*coeff; holds its value until the next done.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; counter=0; acc=0; coeff_q=0; product=0.
  - done=0, sr_load=0, sr_enable=0, busy=0.
  - Reset mid-operation aborts the operation with no done pulse; product returns to 0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: coeff_q<=coeff, acc<=0, counter<=0, go to LOAD.
  - start=0: stay in IDLE.
- LOAD:
  - Exactly one cycle; sr_load=1 combinationally from state, sr_enable=0.
  - Upstream loads the sample at the closing edge. Go to SHIFT.
- SHIFT:
  - sr_enable = ~hold; sr_load=0.
  - On each edge with hold=0, sample_bit is weight k=counter:
    - k<N-1: acc <= acc + (sample_bit ? sext(coeff_q)<<k : 0).
    - k=N-1 (sign bit): acc <= acc - (sample_bit ? sext(coeff_q)<<(N-1) : 0).
    - counter <= counter+1.
  - On each edge with hold=1: counter and acc unchanged; upstream does not shift because sr_enable=0.
  - After the k=N-1 update (same edge): product <= final acc value, done<=1 (registered), go to DONE.
- DONE:
  - One cycle; done=1, busy=1.
  - Next edge: done<=0, go to IDLE.
  - start is not accepted in DONE.
- start while busy is ignored, not queued.
- Latency with hold=0:
  - start sampled at edge E0.
  - LOAD occupies the cycle after E0.
  - SHIFT covers N cycles.
  - done is high in cycle N+2 after E0.
  - Each hold cycle in SHIFT adds exactly one cycle.
- Arithmetic:
  - All sums are P-bit two's complement; no overflow is possible.
  - Extreme case (-2^(N-1))*(-2^(C-1)) = 2^(N+C-2) fits in P.
- Minimum start-to-start spacing is N+3 cycles; a start held high continuously restarts in the IDLE cycle after DONE.
- hold is ignored in IDLE, LOAD and DONE.

Test Plan:
- Reset, then start with coeff=16'h0001 while the upstream register (shift_in=0) is loaded with 20'hAAAAA, hold=0 -> sr_load high one cycle, sr_enable high 20 cycles, done at cycle 22, product=36'hFFFFAAAAA (-349526).
- Sample 20'h55555, coeff=16'h0003, hold=0 -> product=36'h0000FFFFF (1048575); busy high for cycles 1..22, low at 23.
- Sample 20'h80000, coeff=16'h8000 -> product=36'h400000000; then sample 20'hFFFFF, coeff=16'h7FFF -> product=36'hFFFFF8001 (-32767).
- Sample 20'hAAAAA, coeff=16'h0005, hold randomized each negedge+quarter-period (seeded) -> product=36'hFFFE55552 (-1747630); done delayed by exactly the count of hold=1 SHIFT cycles; sr_enable never high while hold=1.
- start re-asserted during SHIFT with coeff=16'h7FFF -> ignored; product still from the original coeff. start held high continuously -> back-to-back operations every 23 cycles.
- resetn pulsed low mid-SHIFT (counter=10) -> all outputs 0 immediately with no clock; no done pulse; next start completes normally with the correct product.
